filter_stream_engine: RTL and testbench
=======================================

FILTER_STREAM_ENGINE -- requirements
Module: filter_stream_engine

Interface
REQ-001 SHALL have parameter WORDLENGTH, default 14, sample width in bits.
REQ-002 SHALL have parameter FRACTIONAL_LENGTH, default 6, fractional bits; samples are two's-complement fixed point, passed through unmodified.
REQ-003 SHALL have parameter DEPTH, default 128, stimulus and capture memory depth (power of 2, >=4).
REQ-004 SHALL have parameter LATENCY, default 1, filter pipeline delay in cycles (range 1..8).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port srst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports wr_en  in  1 / wr_addr  in  $clog2(DEPTH) / wr_data  in  WORDLENGTH  stimulus memory write.
REQ-008 SHALL have port start  in  1  run request, sampled each edge.
REQ-009 SHALL have port ctrl_in  in  1  filter mode for the run (1 integrator, 0 differentiator).
REQ-010 SHALL have ports filt_ctrl  out  1 / filt_s_tdata  out  WORDLENGTH / filt_s_tvalid  out  1  filter-side stimulus.
REQ-011 SHALL have port filt_m_tdata  in  WORDLENGTH  filter output.
REQ-012 SHALL have ports rd_en  in  1 / rd_addr  in  $clog2(DEPTH) / rd_data  out  WORDLENGTH / rd_valid  out  1  capture memory readback.
REQ-013 SHALL have ports busy  out  1 / done  out  1  run status; done is a 1-cycle pulse.

Function
REQ-014 SHALL implement FSM states IDLE, STREAM, DRAIN; reset state IDLE.
REQ-015 SHALL, in IDLE with wr_en=1, write wr_data to stim[wr_addr] at the edge; wr_en outside IDLE is ignored.
REQ-016 SHALL, in IDLE with start=1 at edge E0, latch ctrl_in into filt_ctrl, assert busy, enter STREAM; start outside IDLE is ignored.
REQ-017 SHALL, on simultaneous wr_en and start in IDLE, perform the write first, so the written value is used by the run.
REQ-018 SHALL present stim[k] on filt_s_tdata with filt_s_tvalid=1 from edge E0+k+1 to E0+k+2, for k=0..DEPTH-1, one sample per cycle, no gaps.
REQ-019 SHALL use an issue counter of $clog2(DEPTH) bits; on issuing index DEPTH-1 it wraps to 0 and the FSM enters DRAIN.
REQ-020 SHALL, in DRAIN, drive filt_s_tdata=0 and filt_s_tvalid=0 for LATENCY cycles.
REQ-021 SHALL sample filt_m_tdata at edge E0+k+1+LATENCY into cap[k], for k=0..DEPTH-1; no other cap writes occur.
REQ-022 SHALL, at edge E0+DEPTH+LATENCY+1, return to IDLE, deassert busy and assert done for exactly one cycle.
REQ-023 SHALL hold filt_ctrl constant for the whole run; in IDLE filt_ctrl keeps its last latched value.
REQ-024 SHALL, in IDLE with rd_en=1 at edge E, drive rd_data=cap[rd_addr] and rd_valid=1 after E for one cycle (latency 1); rd_en while busy yields rd_valid=0 and rd_data holds its previous value.
REQ-025 SHALL allow back-to-back runs: start asserted in the cycle done is high begins a new run at that edge.
REQ-026 SHALL never overflow: total run length is exactly DEPTH+LATENCY+1 cycles from E0.

Reset
REQ-027 SHALL, on srst=1 at any time, asynchronously force: state IDLE, busy=0, done=0, filt_s_tvalid=0, filt_s_tdata=0, filt_ctrl=0, rd_valid=0, rd_data=0, counters=0.
REQ-028 SHALL retain stim and cap memory contents across reset (not cleared); a run aborted by reset leaves cap partially updated.
REQ-029 SHALL ignore start, wr_en, rd_en while srst=1; first accepted start is at the first edge with srst=0.

Verification
REQ-030 Load stim[k]=k (k=0..127), LATENCY=1, loopback filt_m_tdata=filt_s_tdata delayed 1 cycle, start, ctrl_in=1 -> filt_s_tdata 0..127 on consecutive cycles, done at E0+130, readback cap[k]=k, filt_ctrl=1 throughout.
REQ-031 Same load, LATENCY=4, loopback delay 4 -> cap[k]=k, busy high 133 cycles, filt_s_tvalid low for last 4 busy cycles.
REQ-032 Assert srst asynchronously (mid-cycle) at E0+50 -> all outputs 0 immediately, busy=0, no done pulse; then readback cap[0..48]=k, stim unchanged; new start runs correctly.
REQ-033 wr_en to stim[5]=0x3FFF and rd_en while busy -> stim[5] unchanged, rd_valid stays 0; start pulses while busy -> no restart, done once.
REQ-034 In IDLE, wr_en stim[0]=0x2A00 and start on the same edge -> first issued sample 0x2A00; start again during done cycle -> second run begins with no idle gap.

Source files
------------

// File: rtl/filter_stream_engine_if.sv
// Signal bundle for filter_stream_engine: stimulus load, run control,
// filter-side stream and capture readback.
interface filter_stream_engine_if #(
  parameter int unsigned WORDLENGTH = 14,
  parameter int unsigned DEPTH      = 128
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WORDLENGTH-1:0] wr_data;
  logic                  start;
  logic                  ctrl_in;
  logic                  filt_ctrl;
  logic [WORDLENGTH-1:0] filt_s_tdata;
  logic                  filt_s_tvalid;
  logic [WORDLENGTH-1:0] filt_m_tdata;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic [WORDLENGTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  busy;
  logic                  done;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, ctrl_in, filt_m_tdata, rd_en, rd_addr,
    output filt_ctrl, filt_s_tdata, filt_s_tvalid, rd_data, rd_valid, busy, done
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, ctrl_in, filt_m_tdata, rd_en, rd_addr,
    input  filt_ctrl, filt_s_tdata, filt_s_tvalid, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/filter_stream_engine.sv
// Streams a stimulus memory through an external filter of fixed latency and
// captures the filter output into a readback memory, one run per start.
module filter_stream_engine #(
  parameter int unsigned WORDLENGTH        = 14,
  parameter int unsigned FRACTIONAL_LENGTH = 6,
  parameter int unsigned DEPTH             = 128,
  parameter int unsigned LATENCY           = 1
) (
  input logic                   clk,
  input logic                   srst,
  filter_stream_engine_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(DEPTH + LATENCY + 1);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 4");
  end
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("LATENCY must be in 1..8");
  end
  if (FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_bad_frac
    $error("FRACTIONAL_LENGTH must be smaller than WORDLENGTH");
  end

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e                state_q;
  logic [AW-1:0]         issue_cnt_q;
  logic [AW-1:0]         cap_cnt_q;
  logic [RW-1:0]         run_cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  filt_ctrl_q;
  logic                  filt_s_tvalid_q;
  logic [WORDLENGTH-1:0] filt_s_tdata_q;
  logic                  rd_valid_q;
  logic [WORDLENGTH-1:0] rd_data_q;

  logic [WORDLENGTH-1:0] stim_mem [DEPTH];
  logic [WORDLENGTH-1:0] cap_mem  [DEPTH];

  logic stim_we;
  logic cap_we;

  // run_cnt_q holds (edges since start - 1); sample k returns LATENCY edges after it was issued.
  assign stim_we = (state_q == StIdle) && bus.wr_en && !srst;
  assign cap_we  = (state_q != StIdle) && (run_cnt_q >= RW'(LATENCY)) &&
                   (run_cnt_q < RW'(DEPTH + LATENCY));

  // Memories are not reset so contents survive an aborted run.
  always_ff @(posedge clk) begin
    if (stim_we) stim_mem[bus.wr_addr] <= bus.wr_data;
    if (cap_we)  cap_mem[cap_cnt_q]    <= bus.filt_m_tdata;
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q         <= StIdle;
      issue_cnt_q     <= '0;
      cap_cnt_q       <= '0;
      run_cnt_q       <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      filt_ctrl_q     <= 1'b0;
      filt_s_tvalid_q <= 1'b0;
      filt_s_tdata_q  <= '0;
      rd_valid_q      <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      if (cap_we) cap_cnt_q <= cap_cnt_q + 1'b1;
      case (state_q)
        StIdle: begin
          if (bus.rd_en) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= cap_mem[bus.rd_addr];
          end
          if (bus.start) begin
            state_q     <= StStream;
            busy_q      <= 1'b1;
            filt_ctrl_q <= bus.ctrl_in;
            issue_cnt_q <= '0;
            cap_cnt_q   <= '0;
            run_cnt_q   <= '0;
          end
        end
        StStream: begin
          filt_s_tdata_q  <= stim_mem[issue_cnt_q];
          filt_s_tvalid_q <= 1'b1;
          issue_cnt_q     <= issue_cnt_q + 1'b1;
          run_cnt_q       <= run_cnt_q + 1'b1;
          if (issue_cnt_q == AW'(DEPTH - 1)) state_q <= StDrain;
        end
        StDrain: begin
          filt_s_tdata_q  <= '0;
          filt_s_tvalid_q <= 1'b0;
          run_cnt_q       <= run_cnt_q + 1'b1;
          if (run_cnt_q == RW'(DEPTH + LATENCY)) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            run_cnt_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.filt_ctrl     = filt_ctrl_q;
  assign bus.filt_s_tvalid = filt_s_tvalid_q;
  assign bus.filt_s_tdata  = filt_s_tdata_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
endmodule

// File: tb/tb_filter_stream_engine.sv
// Directed bench: two engines (LATENCY 1 and 4) share stimulus; a timing model
// predicts every output each cycle from the run start edge.
module tb_filter_stream_engine;
  localparam int WL = 14;
  localparam int D  = 128;
  localparam int AW = $clog2(D);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst;
  logic          start;
  logic          ctrl_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WL-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  filter_stream_engine_if #(.WORDLENGTH(WL), .DEPTH(D)) if1 ();
  filter_stream_engine_if #(.WORDLENGTH(WL), .DEPTH(D)) if4 ();

  assign if1.start = start;   assign if4.start = start;
  assign if1.ctrl_in = ctrl_in; assign if4.ctrl_in = ctrl_in;
  assign if1.wr_en = wr_en;   assign if4.wr_en = wr_en;
  assign if1.wr_addr = wr_addr; assign if4.wr_addr = wr_addr;
  assign if1.wr_data = wr_data; assign if4.wr_data = wr_data;
  assign if1.rd_en = rd_en;   assign if4.rd_en = rd_en;
  assign if1.rd_addr = rd_addr; assign if4.rd_addr = rd_addr;

  // An L-cycle filter: a sample launched at edge t is sampled back at edge t+L.
  logic [WL-1:0] lb_pipe [3];
  always @(posedge clk) begin
    lb_pipe[0] <= if4.filt_s_tdata;
    lb_pipe[1] <= lb_pipe[0];
    lb_pipe[2] <= lb_pipe[1];
  end
  assign if1.filt_m_tdata = if1.filt_s_tdata;
  assign if4.filt_m_tdata = lb_pipe[2];

  filter_stream_engine #(
    .WORDLENGTH(WL), .FRACTIONAL_LENGTH(6), .DEPTH(D), .LATENCY(1)
  ) u_dut1 (
    .clk  (clk),
    .srst (srst),
    .bus  (if1)
  );

  filter_stream_engine #(
    .WORDLENGTH(WL), .FRACTIONAL_LENGTH(6), .DEPTH(D), .LATENCY(4)
  ) u_dut4 (
    .clk  (clk),
    .srst (srst),
    .bus  (if4)
  );

  int            n_checks;
  int            n_fails;
  int            cyc;
  int            e0 [2];
  logic [WL-1:0] stim_m [2][D];
  logic [WL-1:0] cap_m  [2][D];
  logic          ctrl_m [2];
  logic          rd_valid_m [2];
  logic [WL-1:0] rd_data_m [2];
  int            busy_cnt [2];
  int            done_cnt [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Effect of one clock edge on instance i (only called while srst is low).
  task automatic model_edge(input int i);
    int l;
    int n;
    bit idle;
    l    = lat_of(i);
    n    = cyc - e0[i];
    idle = (e0[i] < 0) || (n > D + l + 1);
    if (!idle && n >= 1 + l && n <= D + l) cap_m[i][n-1-l] = stim_m[i][n-1-l];
    rd_valid_m[i] = idle && rd_en;
    if (idle && rd_en) rd_data_m[i] = cap_m[i][rd_addr];
    if (idle && wr_en) stim_m[i][wr_addr] = wr_data;
    if (idle && start) begin
      e0[i]     = cyc;
      ctrl_m[i] = ctrl_in;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      e0[i]         = -1;
      ctrl_m[i]     = 1'b0;
      rd_valid_m[i] = 1'b0;
      rd_data_m[i]  = '0;
    end
  endtask

  task automatic compare_dut(input int i);
    int            l;
    int            n;
    logic          vld;
    logic [WL-1:0] td;
    logic [32:0]   got;
    logic [32:0]   exp;
    l   = lat_of(i);
    n   = cyc - e0[i];
    vld = (e0[i] >= 0) && (n >= 1) && (n <= D);
    td  = '0;
    if (vld) td = stim_m[i][n-1];
    exp = {(e0[i] >= 0 && n <= D + l), (e0[i] >= 0 && n == D + l + 1), vld,
           ctrl_m[i], rd_valid_m[i], td, rd_data_m[i]};
    if (i == 0)
      got = {if1.busy, if1.done, if1.filt_s_tvalid, if1.filt_ctrl, if1.rd_valid,
             if1.filt_s_tdata, if1.rd_data};
    else
      got = {if4.busy, if4.done, if4.filt_s_tvalid, if4.filt_ctrl, if4.rd_valid,
             if4.filt_s_tdata, if4.rd_data};
    if (got[32]) busy_cnt[i]++;
    if (got[31]) done_cnt[i]++;
    check($sformatf("outs_lat%0d_cyc%0d", l, cyc), 64'(got), 64'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!srst) begin
      model_edge(0);
      model_edge(1);
    end
    #1;
    compare_dut(0);
    compare_dut(1);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      busy_cnt[i] = 0;
      done_cnt[i] = 0;
    end
  endtask

  task automatic load_stim(input logic [WL-1:0] base);
    for (int k = 0; k < D; k++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(k);
      wr_data = base + WL'(k);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic readback();
    for (int k = 0; k < D; k++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(k);
      step();
    end
    rd_en = 1'b0;
    step();
  endtask

  // Full run; with disturb, writes/reads/starts/ctrl toggles are thrown in while busy.
  task automatic run(input logic ctl, input bit disturb);
    clear_counts();
    ctrl_in = ctl;
    start   = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= D + 8; n++) begin
      if (disturb) begin
        ctrl_in = n[0];
        wr_en   = (n == 60);
        wr_addr = AW'(5);
        wr_data = 14'h3fff;
        rd_en   = (n == 60);
        rd_addr = AW'(3);
        start   = (n == 60) || (n == 100);
      end
      step();
    end
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    start   = 1'b0;
    ctrl_in = ctl;
    check("busy_cycles_lat1", 64'(busy_cnt[0]), 64'(D + 2));
    check("busy_cycles_lat4", 64'(busy_cnt[1]), 64'(D + 5));
    check("done_pulses_lat1", 64'(done_cnt[0]), 64'd1);
    check("done_pulses_lat4", 64'(done_cnt[1]), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    cyc      = 0;
    model_reset();
    srst    = 1'b1;
    start   = 1'b1;
    ctrl_in = 1'b1;
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = '0;
    rd_en   = 1'b1;
    rd_addr = '0;

    // Requests while in reset must be ignored.
    repeat (3) step();
    start   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ctrl_in = 1'b0;
    srst    = 1'b0;
    step();

    // Fill cap with a distinct pattern so a partial later run is visible.
    load_stim(14'h1000);
    run(1'b0, 1'b0);
    readback();

    // Run aborted by an asynchronous reset mid-cycle after edge E0+50.
    load_stim(14'h0000);
    clear_counts();
    ctrl_in = 1'b1;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (50) step();
    #3;
    srst = 1'b1;
    model_reset();
    #1;
    compare_dut(0);
    compare_dut(1);
    step();
    step();
    srst = 1'b0;
    step();
    check("abort_done_lat1", 64'(done_cnt[0]), 64'd0);
    check("abort_done_lat4", 64'(done_cnt[1]), 64'd0);
    readback();

    // Clean run on the unchanged stimulus, then one with disturbances while busy.
    run(1'b1, 1'b0);
    readback();
    run(1'b1, 1'b1);

    // Write and start on the same edge, then back-to-back start during done.
    clear_counts();
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 14'h2a00;
    ctrl_in = 1'b1;
    start   = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    step();
    check("first_sample_lat1", 64'(if1.filt_s_tdata), 64'(14'h2a00));
    check("first_sample_lat4", 64'(if4.filt_s_tdata), 64'(14'h2a00));
    for (int n = 2; n <= 2 * D + 12; n++) begin
      start = (n == D + 3);
      if (n == D + 3) ctrl_in = 1'b0;
      step();
      if (n == D + 3) check("b2b_busy_lat1", 64'(if1.busy), 64'd1);
    end
    start = 1'b0;
    check("b2b_done_lat1", 64'(done_cnt[0]), 64'd2);
    check("b2b_done_lat4", 64'(done_cnt[1]), 64'd1);
    check("b2b_ctrl_lat1", 64'(if1.filt_ctrl), 64'd0);
    check("b2b_ctrl_lat4", 64'(if4.filt_ctrl), 64'd1);
    readback();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
